axi_lite_slave: RTL and testbench
=================================

// Module: axi_lite_slave
// PURPOSE
//  AXI4-lite slave endpoint; sits directly downstream of axi_master on the system bus.
//  Buffers AW/W/AR beats independently and turns each transaction into one cycle on a
//  simple synchronous-SRAM/register port. Returns B/R responses, with SLVERR for
//  out-of-window addresses.
//  Single outstanding transaction; no bursts, IDs or PROT checking.
// PARAMETERS
//  AXI_ADDR_WIDTH  32   AXI address width
//  AXI_DATA_WIDTH  32   AXI data width; STRB width = AXI_DATA_WIDTH/8
//  BASE_ADDR       32'h0  byte base of the decoded window (aligned to window size)
//  MEM_AW          10   word-address bits; window = 4*2**MEM_AW bytes
// PORTS
//  ACLK       in   1    bus clock; the only clock
//  ARESETn    in   1    asynchronous, active-low reset
//  AWVALID    in   1    write address valid
//  AWREADY    out  1    = !aw_full
//  AWADDR     in   AXI_ADDR_WIDTH   write byte address
//  AWPROT     in   3    ignored
//  WVALID     in   1    write data valid
//  WREADY     out  1    = !w_full
//  WDATA      in   AXI_DATA_WIDTH   write data
//  WSTRB      in   AXI_DATA_WIDTH/8 byte strobes
//  BVALID     out  1    write response valid
//  BREADY     in   1    write response accept
//  BRESP      out  2    2'b00 OKAY / 2'b10 SLVERR
//  ARVALID    in   1    read address valid
//  ARREADY    out  1    = !ar_full
//  ARADDR     in   AXI_ADDR_WIDTH   read byte address
//  ARPROT     in   3    ignored
//  RVALID     out  1    read data valid
//  RREADY     in   1    read data accept
//  RDATA      out  AXI_DATA_WIDTH   read data; 0 on SLVERR
//  RRESP      out  2    as BRESP
//  mem_cs     out  1    local access strobe, exactly one cycle per in-window transaction
//  mem_we     out  1    1 = write; valid only while mem_cs is high
//  mem_addr   out  MEM_AW  word address = addr[MEM_AW+1:2]
//  mem_wdata  out  AXI_DATA_WIDTH   captured WDATA
//  mem_wstrb  out  AXI_DATA_WIDTH/8 captured WSTRB
//  mem_rdata  in   AXI_DATA_WIDTH   valid the cycle after a read mem_cs (1-cycle latency)
// BEHAVIOUR
//  Reset:
//   - state IDLE; aw/w/ar holding regs empty.
//   - BVALID, RVALID, mem_cs, mem_we = 0; BRESP, RRESP, RDATA, mem_* buses = 0.
//   - AWREADY, WREADY, ARREADY = 1.
//  Capture:
//   - Handshake (VALID & READY at an edge) loads the holding reg and sets its full flag.
//   - AW and W may arrive in either order or in the same cycle.
//  Decode:
//   - hit = (addr & ~(4*2**MEM_AW-1)) == BASE_ADDR.
//   - addr[1:0] is ignored, not an error.
//  FSM states: IDLE, WR, BRSP, RD, RWAIT, RRSP.
//   - IDLE:
//     - wr_pend = aw_full & w_full; rd_pend = ar_full.
//     - Only one pending: go to WR or RD.
//     - Both pending: grant the opposite of last_grant (bit, reset = read, so write wins first).
//   - WR (1 cycle): mem_cs = hit, mem_we = 1; latch BRESP = hit ? 00 : 10; -> BRSP.
//   - BRSP: BVALID = 1, held stable until BREADY. On handshake: clear aw_full and w_full -> IDLE.
//   - RD (1 cycle): mem_cs = hit, mem_we = 0; -> RWAIT.
//   - RWAIT (1 cycle): register RDATA = hit ? mem_rdata : 0 and RRESP; -> RRSP.
//   - RRSP: RVALID = 1, held until RREADY. On handshake: clear ar_full -> IDLE.
//  Latency:
//   - Write: BVALID rises 2 edges after the later AW/W handshake.
//   - Read: RVALID rises 3 edges after the AR handshake.
//   - Both assume IDLE at the handshake and no competing grant.
//  Boundaries:
//   - READY reflects the registered full flag, so a freed slot accepts the next beat one cycle later.
//   - Out-of-window access never asserts mem_cs.
//   - WSTRB = 0: write cycle still issued, OKAY returned.
//   - A second AW/W/AR arriving while its slot is full stalls via READY = 0.
//   - Reset mid-operation drops all VALIDs immediately (asynchronous reset) and discards buffered beats.
// STRUCTURE
//  - axi_defines.vh gains: RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, the six state encodings.
//  - Sub-module axi_chan_hold: VALID/READY one-entry holding register with full flag,
//    parameterised width, plus a clear input. Instantiated for AW, W and AR.
// TESTING
//  1. Write 0x10 <- 0xDEADBEEF, STRB F -> one mem_cs/we, mem_addr 4, BRESP 00;
//     read 0x10 -> RDATA 0xDEADBEEF, RRESP 00.
//  2. W issued 3 cycles before AW -> WREADY low after W; exactly one mem write after AW;
//     BVALID 2 edges after the AW handshake.
//  3. Address BASE+0x1000 (MEM_AW = 10) write and read -> mem_cs never high;
//     BRESP 10, RRESP 10, RDATA 0.
//  4. BREADY held low 5 cycles -> BVALID and BRESP stable;
//     AWREADY stays 0 until the handshake, then 1 one cycle later.
//  5. Write and read pending together, twice -> order W, R, then R, W;
//     each completes with correct data.
//  6. ARESETn pulsed low during RRSP -> RVALID 0 asynchronously; after release, READYs = 1,
//     and a fresh read completes normally.

Source files
------------

// File: rtl/axi_lite_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_slave_pkg
//   Shared definitions for the AXI4-lite slave endpoint: response codes,
//   controller state encoding, arbitration-grant encoding and the helper that
//   derives the byte-offset mask of the decoded address window.
// -----------------------------------------------------------------------------
package axi_lite_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        BRSP  = 3'd2,
        RD    = 3'd3,
        RWAIT = 3'd4,
        RRSP  = 3'd5
    } state_t;

    // Which side won the most recent contended arbitration.
    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

    // Byte-offset mask of a window holding 2**mem_aw 32-bit words.
    function automatic logic [63:0] window_offset_mask(input int unsigned mem_aw);
        return (64'd4 << mem_aw) - 64'd1;
    endfunction

endpackage

// File: rtl/axi_lite_slave_if.sv
// -----------------------------------------------------------------------------
// axi_lite_slave_if
//   AXI4-lite bus bundle (AW, W, B, AR, R channels) between a master and the
//   axi_lite_slave endpoint. Clock and reset are not part of the bundle.
//   Modports:
//     master : drives AW*/W*/AR* VALID+payload, BREADY, RREADY
//     slave  : drives AWREADY, WREADY, ARREADY, B* and R* VALID+payload
// -----------------------------------------------------------------------------
interface axi_lite_slave_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
);

    logic                          AWVALID;
    logic                          AWREADY;
    logic [AXI_ADDR_WIDTH-1:0]     AWADDR;
    logic [2:0]                    AWPROT;

    logic                          WVALID;
    logic                          WREADY;
    logic [AXI_DATA_WIDTH-1:0]     WDATA;
    logic [AXI_DATA_WIDTH/8-1:0]   WSTRB;

    logic                          BVALID;
    logic                          BREADY;
    logic [1:0]                    BRESP;

    logic                          ARVALID;
    logic                          ARREADY;
    logic [AXI_ADDR_WIDTH-1:0]     ARADDR;
    logic [2:0]                    ARPROT;

    logic                          RVALID;
    logic                          RREADY;
    logic [AXI_DATA_WIDTH-1:0]     RDATA;
    logic [1:0]                    RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT,
        output WVALID, WDATA, WSTRB,
        output BREADY,
        output ARVALID, ARADDR, ARPROT,
        output RREADY,
        input  AWREADY, WREADY, BVALID, BRESP,
        input  ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT,
        input  WVALID, WDATA, WSTRB,
        input  BREADY,
        input  ARVALID, ARADDR, ARPROT,
        input  RREADY,
        output AWREADY, WREADY, BVALID, BRESP,
        output ARREADY, RVALID, RDATA, RRESP
    );

endinterface

// File: rtl/axi_lite_slave_chan_hold.sv
// -----------------------------------------------------------------------------
// axi_chan_hold
//   One-entry VALID/READY holding register for a single AXI channel.
//   A handshake loads the payload and sets 'full'; 'clear' empties the slot.
//   READY is the inverse of the registered full flag, so a freed slot takes
//   the next beat one cycle after it is cleared.
//   Ports:
//     ACLK, ARESETn : clock, asynchronous active-low reset
//     in_valid      : channel VALID from the master
//     in_ready      : channel READY to the master (= !full)
//     in_data       : channel payload
//     clear         : release the held beat
//     full          : slot occupied
//     data          : held payload
// -----------------------------------------------------------------------------
module axi_chan_hold #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    assign in_ready = !full;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            full <= 1'b0;
            data <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
            data <= in_data;
        end
    end

endmodule

// File: rtl/axi_lite_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_slave
//   AXI4-lite slave endpoint. AW, W and AR beats are buffered independently;
//   each complete transaction becomes a single cycle on a synchronous
//   SRAM/register port (1-cycle read latency). Accesses outside the window
//   [BASE_ADDR, BASE_ADDR + 4*2**MEM_AW) get SLVERR and never reach the port.
//   One transaction outstanding at a time; no bursts, IDs or PROT checking.
//   Ports:
//     ACLK, ARESETn : clock, asynchronous active-low reset
//     s_axi         : AXI4-lite bus (slave modport)
//     mem_cs        : one-cycle access strobe per in-window transaction
//     mem_we        : 1 = write (meaningful only with mem_cs)
//     mem_addr      : word address (byte address bits [MEM_AW+1:2])
//     mem_wdata     : write data
//     mem_wstrb     : byte strobes
//     mem_rdata     : read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module axi_lite_slave
    import axi_lite_slave_pkg::*;
#(
    parameter int unsigned                AXI_ADDR_WIDTH = 32,
    parameter int unsigned                AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter int unsigned                MEM_AW         = 10
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    axi_lite_slave_if.slave               s_axi,
    output logic                          mem_cs,
    output logic                          mem_we,
    output logic [MEM_AW-1:0]             mem_addr,
    output logic [AXI_DATA_WIDTH-1:0]     mem_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   mem_wstrb,
    input  logic [AXI_DATA_WIDTH-1:0]     mem_rdata
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] OFS_MASK =
        AXI_ADDR_WIDTH'(window_offset_mask(MEM_AW));

    state_t state, state_nxt;
    grant_t last_grant;

    logic                       aw_full, w_full, ar_full;
    logic [AXI_ADDR_WIDTH-1:0]  aw_addr, ar_addr;
    logic [AXI_DATA_WIDTH-1:0]  w_data;
    logic [STRB_W-1:0]          w_strb;

    logic                       wr_pend, rd_pend, contended;
    logic                       wr_done, rd_done;
    logic                       aw_hit, ar_hit;

    logic [1:0]                 bresp_q, rresp_q;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q;
    logic                       bvalid, rvalid;

    logic                       unused_prot;

    // ---------------------------------------------------------------- holding
    assign wr_done = (state == BRSP) && s_axi.BREADY;
    assign rd_done = (state == RRSP) && s_axi.RREADY;

    axi_chan_hold #(.WIDTH(AXI_ADDR_WIDTH)) u_aw_hold (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .in_valid (s_axi.AWVALID),
        .in_ready (s_axi.AWREADY),
        .in_data  (s_axi.AWADDR),
        .clear    (wr_done),
        .full     (aw_full),
        .data     (aw_addr)
    );

    axi_chan_hold #(.WIDTH(AXI_DATA_WIDTH + STRB_W)) u_w_hold (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .in_valid (s_axi.WVALID),
        .in_ready (s_axi.WREADY),
        .in_data  ({s_axi.WSTRB, s_axi.WDATA}),
        .clear    (wr_done),
        .full     (w_full),
        .data     ({w_strb, w_data})
    );

    axi_chan_hold #(.WIDTH(AXI_ADDR_WIDTH)) u_ar_hold (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .in_valid (s_axi.ARVALID),
        .in_ready (s_axi.ARREADY),
        .in_data  (s_axi.ARADDR),
        .clear    (rd_done),
        .full     (ar_full),
        .data     (ar_addr)
    );

    // ----------------------------------------------------------------- decode
    // Byte-lane bits [1:0] fall inside the offset mask, so they never cause a miss.
    assign aw_hit = (aw_addr & ~OFS_MASK) == BASE_ADDR;
    assign ar_hit = (ar_addr & ~OFS_MASK) == BASE_ADDR;

    // PROT is accepted but carries no meaning for this endpoint.
    assign unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

    // --------------------------------------------------------- state register
    // last_grant only moves on a contended choice, so back-to-back contention
    // alternates W/R while uncontested traffic leaves the priority untouched.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            last_grant <= GRANT_RD;
        end else begin
            state <= state_nxt;
            if (contended) begin
                last_grant <= (state_nxt == WR) ? GRANT_WR : GRANT_RD;
            end
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        wr_pend   = aw_full && w_full;
        rd_pend   = ar_full;
        contended = 1'b0;
        case (state)
            IDLE: begin
                if (wr_pend && rd_pend) begin
                    contended = 1'b1;
                    state_nxt = (last_grant == GRANT_RD) ? WR : RD;
                end else if (wr_pend) begin
                    state_nxt = WR;
                end else if (rd_pend) begin
                    state_nxt = RD;
                end
            end
            WR:      state_nxt = BRSP;
            BRSP:    if (s_axi.BREADY) state_nxt = IDLE;
            RD:      state_nxt = RWAIT;
            RWAIT:   state_nxt = RRSP;
            RRSP:    if (s_axi.RREADY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        bvalid    = 1'b0;
        rvalid    = 1'b0;
        case (state)
            WR: begin
                mem_cs    = aw_hit;
                mem_we    = 1'b1;
                mem_addr  = aw_addr[MEM_AW+1:2];
                mem_wdata = w_data;
                mem_wstrb = w_strb;
            end
            RD: begin
                mem_cs   = ar_hit;
                mem_addr = ar_addr[MEM_AW+1:2];
            end
            BRSP:    bvalid = 1'b1;
            RRSP:    rvalid = 1'b1;
            default: ;
        endcase
    end

    // ----------------------------------------------------- response registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
            rdata_q <= '0;
        end else begin
            if (state == WR) begin
                bresp_q <= aw_hit ? RESP_OKAY : RESP_SLVERR;
            end
            // mem_rdata belongs to the strobe issued in RD, one cycle earlier.
            if (state == RWAIT) begin
                rresp_q <= ar_hit ? RESP_OKAY : RESP_SLVERR;
                rdata_q <= ar_hit ? mem_rdata : '0;
            end
        end
    end

    assign s_axi.BVALID = bvalid;
    assign s_axi.BRESP  = bresp_q;
    assign s_axi.RVALID = rvalid;
    assign s_axi.RRESP  = rresp_q;
    assign s_axi.RDATA  = rdata_q;

endmodule

// File: tb/tb_axi_lite_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_slave
//   Directed self-checking bench for axi_lite_slave (BASE_ADDR 0, MEM_AW 10).
//   A small SRAM model sits on the mem_* port with 1-cycle read latency.
// -----------------------------------------------------------------------------
module tb_axi_lite_slave;

    logic        ACLK;
    logic        ARESETn;
    logic        mem_cs;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    axi_lite_slave_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

    axi_lite_slave #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32),
        .BASE_ADDR      (32'h0),
        .MEM_AW         (10)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .s_axi     (bus),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ------------------------------------------------------------ SRAM model
    logic [31:0] mem [0:1023];
    int          cs_count = 0;
    logic [1:0]  op_hist  = 2'b00;
    logic [9:0]  last_waddr = '0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
    end

    always @(posedge ACLK) begin
        if (mem_cs) begin
            cs_count <= cs_count + 1;
            op_hist  <= {op_hist[0], mem_we};
            if (mem_we) begin
                last_waddr <= mem_addr;
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    // --------------------------------------------------------------- drivers
    // All drivers are entered and left 1 time unit after a rising edge.
    task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output bit ok);
        bit aw_hs, w_hs;
        ok = 1'b0;
        bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            @(posedge ACLK); #1;
            if (aw_hs) bus.AWVALID = 1'b0;
            if (w_hs)  bus.WVALID  = 1'b0;
            if (!bus.AWVALID && !bus.WVALID) begin
                ok = 1'b1;
                break;
            end
        end
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output bit ok);
        ok = 1'b0; resp = 2'b11;
        bus.BREADY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (bus.BVALID) begin
                resp = bus.BRESP;
                @(posedge ACLK); #1;
                ok = 1'b1;
                break;
            end
            @(posedge ACLK); #1;
        end
        bus.BREADY = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, output bit ok);
        ok = 1'b0;
        bus.ARADDR = addr; bus.ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (bus.ARREADY) begin
                @(posedge ACLK); #1;
                ok = 1'b1;
                break;
            end
            @(posedge ACLK); #1;
        end
        bus.ARVALID = 1'b0;
    endtask

    task automatic wait_r(output logic [31:0] data, output logic [1:0] resp, output bit ok);
        ok = 1'b0; resp = 2'b11; data = 32'hxxxx_xxxx;
        bus.RREADY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (bus.RVALID) begin
                resp = bus.RRESP;
                data = bus.RDATA;
                @(posedge ACLK); #1;
                ok = 1'b1;
                break;
            end
            @(posedge ACLK); #1;
        end
        bus.RREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output bit ok);
        bit ok_a, ok_b;
        send_aw_w(addr, data, strb, ok_a);
        wait_b(resp, ok_b);
        ok = ok_a && ok_b;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok);
        bit ok_a, ok_r;
        send_ar(addr, ok_a);
        wait_r(data, resp, ok_r);
        ok = ok_a && ok_r;
    endtask

    task automatic issue_both(input logic [31:0] waddr, input logic [31:0] wdata,
                              input logic [31:0] raddr, output logic [1:0] bresp,
                              output logic [1:0] rresp, output logic [31:0] rdata,
                              output bit ok);
        bit got_b, got_r, aw_hs, w_hs, ar_hs;
        got_b = 1'b0; got_r = 1'b0;
        bresp = 2'b11; rresp = 2'b11; rdata = 32'hxxxx_xxxx;
        bus.AWADDR = waddr; bus.WDATA = wdata; bus.WSTRB = 4'hF; bus.ARADDR = raddr;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        for (int i = 0; i < 40 && !(got_b && got_r); i++) begin
            @(negedge ACLK);
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            ar_hs = bus.ARVALID && bus.ARREADY;
            if (bus.BVALID && !got_b) begin got_b = 1'b1; bresp = bus.BRESP; end
            if (bus.RVALID && !got_r) begin got_r = 1'b1; rresp = bus.RRESP; rdata = bus.RDATA; end
            @(posedge ACLK); #1;
            if (aw_hs) bus.AWVALID = 1'b0;
            if (w_hs)  bus.WVALID  = 1'b0;
            if (ar_hs) bus.ARVALID = 1'b0;
        end
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        ok = got_b && got_r;
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (2) @(posedge ACLK); #1;
        n_cmp++;
        if ({bus.BVALID, bus.RVALID, mem_cs, mem_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valids: got %b expected 0000", {bus.BVALID, bus.RVALID, mem_cs, mem_we});
        end
        n_cmp++;
        if ({bus.BRESP, bus.RRESP, bus.RDATA} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_resp: got %h expected 0", {bus.BRESP, bus.RRESP, bus.RDATA});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_wstrb} !== 46'h0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata, mem_wstrb});
        end
        n_cmp++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 111", {bus.AWREADY, bus.WREADY, bus.ARREADY});
        end
        @(negedge ACLK); ARESETn = 1'b1;
        @(posedge ACLK); #1;
    endtask

    task automatic test_write_read();
        logic [1:0] resp; logic [31:0] data; bit ok; int cs0;
        cs0 = cs_count;
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, resp, ok);
        n_cmp++;
        if ({ok, resp} !== 3'b1_00) begin
            n_fail++; $display("FAIL wr_bresp: got ok=%b resp=%b expected ok=1 resp=00", ok, resp);
        end
        n_cmp++;
        if (cs_count - cs0 !== 1 || last_waddr !== 10'd4 || mem[4] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL wr_mem: got cs=%0d addr=%0d data=%h expected cs=1 addr=4 data=deadbeef",
                     cs_count - cs0, last_waddr, mem[4]);
        end
        axi_read(32'h10, data, resp, ok);
        n_cmp++;
        if ({ok, resp, data} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL rd_basic: got ok=%b resp=%b data=%h expected 1 00 deadbeef", ok, resp, data);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp; logic [31:0] data; bit ok; int cs0;
        cs0 = cs_count;
        bus.WDATA = 32'h12345678; bus.WSTRB = 4'b0011; bus.WVALID = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        bus.WVALID = 1'b0;
        n_cmp++;
        if (bus.WREADY !== 1'b0) begin
            n_fail++; $display("FAIL w_first_wready: got %b expected 0", bus.WREADY);
        end
        repeat (2) @(posedge ACLK); #1;
        bus.AWADDR = 32'h24; bus.AWVALID = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0;
        n_cmp++;
        if ({bus.BVALID, bus.WREADY} !== 2'b00 || cs_count != cs0) begin
            n_fail++;
            $display("FAIL w_first_early: got bvalid=%b wready=%b cs=%0d expected 0 0 0",
                     bus.BVALID, bus.WREADY, cs_count - cs0);
        end
        @(posedge ACLK); #1;
        n_cmp++;
        if (bus.BVALID !== 1'b0) begin
            n_fail++; $display("FAIL w_first_lat1: got bvalid=%b expected 0", bus.BVALID);
        end
        @(posedge ACLK); #1;
        n_cmp++;
        if (bus.BVALID !== 1'b1) begin
            n_fail++; $display("FAIL w_first_lat2: got bvalid=%b expected 1", bus.BVALID);
        end
        wait_b(resp, ok);
        n_cmp++;
        if ({ok, resp} !== 3'b1_00 || cs_count - cs0 !== 1) begin
            n_fail++; $display("FAIL w_first_done: got ok=%b resp=%b cs=%0d expected 1 00 1", ok, resp, cs_count - cs0);
        end
        axi_read(32'h24, data, resp, ok);
        n_cmp++;
        if ({ok, resp, data} !== {1'b1, 2'b00, 32'h00005678}) begin
            n_fail++; $display("FAIL w_first_strb: got ok=%b resp=%b data=%h expected 1 00 00005678", ok, resp, data);
        end
    endtask

    task automatic test_boundaries();
        logic [1:0] resp; logic [31:0] data; bit ok; int cs0;
        cs0 = cs_count;
        axi_write(32'h1000, 32'hCAFEF00D, 4'hF, resp, ok);
        n_cmp++;
        if ({ok, resp} !== 3'b1_10) begin
            n_fail++; $display("FAIL oow_bresp: got ok=%b resp=%b expected 1 10", ok, resp);
        end
        axi_read(32'h1000, data, resp, ok);
        n_cmp++;
        if ({ok, resp, data} !== {1'b1, 2'b10, 32'h0}) begin
            n_fail++; $display("FAIL oow_read: got ok=%b resp=%b data=%h expected 1 10 00000000", ok, resp, data);
        end
        n_cmp++;
        if (cs_count != cs0) begin
            n_fail++; $display("FAIL oow_cs: got %0d strobes expected 0", cs_count - cs0);
        end
        axi_read(32'h12, data, resp, ok);
        n_cmp++;
        if ({ok, resp, data} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL unaligned_read: got ok=%b resp=%b data=%h expected 1 00 deadbeef", ok, resp, data);
        end
        cs0 = cs_count;
        axi_write(32'h10, 32'hFFFFFFFF, 4'h0, resp, ok);
        n_cmp++;
        if ({ok, resp} !== 3'b1_00 || cs_count - cs0 !== 1) begin
            n_fail++; $display("FAIL strb0_write: got ok=%b resp=%b cs=%0d expected 1 00 1", ok, resp, cs_count - cs0);
        end
        axi_read(32'h10, data, resp, ok);
        n_cmp++;
        if (data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL strb0_readback: got %h expected deadbeef", data);
        end
    endtask

    task automatic test_bready_stall();
        logic [1:0] resp; bit ok; bit seen;
        send_aw_w(32'h30, 32'hA5A50001, 4'hF, ok);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge ACLK); #1;
            if (bus.BVALID) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if ({ok, seen} !== 2'b11) begin
            n_fail++; $display("FAIL stall_bvalid_rise: got ok=%b seen=%b expected 1 1", ok, seen);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge ACLK); #1;
            n_cmp++;
            if ({bus.BVALID, bus.BRESP, bus.AWREADY} !== 4'b1_00_0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got bvalid=%b bresp=%b awready=%b expected 1 00 0",
                         i, bus.BVALID, bus.BRESP, bus.AWREADY);
            end
        end
        bus.BREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.BREADY = 1'b0;
        n_cmp++;
        if ({bus.BVALID, bus.AWREADY, bus.WREADY} !== 3'b011) begin
            n_fail++;
            $display("FAIL stall_release: got bvalid=%b awready=%b wready=%b expected 0 1 1",
                     bus.BVALID, bus.AWREADY, bus.WREADY);
        end
        resp = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [1:0] bresp, rresp; logic [31:0] data; bit ok; int cs0;
        cs0 = cs_count;
        issue_both(32'h40, 32'h11111111, 32'h10, bresp, rresp, data, ok);
        n_cmp++;
        if ({ok, bresp, rresp, data} !== {1'b1, 2'b00, 2'b00, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL arb1_resp: got ok=%b b=%b r=%b data=%h expected 1 00 00 deadbeef", ok, bresp, rresp, data);
        end
        n_cmp++;
        if (op_hist !== 2'b10 || cs_count - cs0 !== 2) begin
            n_fail++; $display("FAIL arb1_order: got hist=%b cs=%0d expected 10 2", op_hist, cs_count - cs0);
        end
        cs0 = cs_count;
        issue_both(32'h44, 32'h22222222, 32'h40, bresp, rresp, data, ok);
        n_cmp++;
        if ({ok, bresp, rresp, data} !== {1'b1, 2'b00, 2'b00, 32'h11111111}) begin
            n_fail++;
            $display("FAIL arb2_resp: got ok=%b b=%b r=%b data=%h expected 1 00 00 11111111", ok, bresp, rresp, data);
        end
        n_cmp++;
        if (op_hist !== 2'b01 || cs_count - cs0 !== 2) begin
            n_fail++; $display("FAIL arb2_order: got hist=%b cs=%0d expected 01 2", op_hist, cs_count - cs0);
        end
        axi_read(32'h44, data, rresp, ok);
        n_cmp++;
        if ({ok, rresp, data} !== {1'b1, 2'b00, 32'h22222222}) begin
            n_fail++; $display("FAIL arb2_readback: got ok=%b r=%b data=%h expected 1 00 22222222", ok, rresp, data);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [31:0] data; bit ok; bit seen;
        send_ar(32'h10, ok);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge ACLK); #1;
            if (bus.RVALID) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if ({ok, seen} !== 2'b11) begin
            n_fail++; $display("FAIL rstmid_rrsp: got ok=%b seen=%b expected 1 1", ok, seen);
        end
        #2 ARESETn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.RVALID, bus.BVALID} !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_async: got rvalid=%b bvalid=%b expected 0 0", bus.RVALID, bus.BVALID);
        end
        @(posedge ACLK);
        @(negedge ACLK); ARESETn = 1'b1;
        @(posedge ACLK); #1;
        n_cmp++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.RVALID} !== 4'b1110) begin
            n_fail++;
            $display("FAIL rstmid_after: got ready=%b rvalid=%b expected 111 0",
                     {bus.AWREADY, bus.WREADY, bus.ARREADY}, bus.RVALID);
        end
        axi_read(32'h40, data, resp, ok);
        n_cmp++;
        if ({ok, resp, data} !== {1'b1, 2'b00, 32'h11111111}) begin
            n_fail++; $display("FAIL rstmid_read: got ok=%b resp=%b data=%h expected 1 00 11111111", ok, resp, data);
        end
    endtask

    initial begin
        ARESETn = 1'b0;
        bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWPROT = 3'b000;
        bus.WVALID  = 1'b0; bus.WDATA  = '0; bus.WSTRB  = '0;
        bus.BREADY  = 1'b0;
        bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARPROT = 3'b000;
        bus.RREADY  = 1'b0;

        test_reset();
        test_write_read();
        test_w_before_aw();
        test_boundaries();
        test_bready_stall();
        test_back_to_back();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
